// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM arbiter: FSM state encoding and ID width.
package ram_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int NREQ_DEF = 2;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W_DEF = id_width(NREQ_DEF);

endpackage

// File: rtl/ram_arb_pick.sv
// Winner selection for the RAM arbiter. RAM_ARB_RR_EN selects round-robin
// (search starts just past ptr_i); otherwise the lowest index wins.
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

`ifdef RAM_ARB_RR_EN
    logic [NREQ-1:0] hi_mask_s;
    logic [NREQ-1:0] hi_s;
    logic [NREQ-1:0] cand_s;

    // Prefer requesters above the last winner; wrap to the full vector if none.
    always_comb begin
        hi_mask_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_mask_s[i] = (IDW'(i) > ptr_i);
        end
        hi_s    = valid_i & hi_mask_s;
        cand_s  = (hi_s != '0) ? hi_s : valid_i;
        grant_o = cand_s & (~cand_s + NREQ'(1));
    end
`else
    logic unused_ptr_s;
    assign unused_ptr_s = ^ptr_i;

    // Isolate the lowest set bit: fixed priority.
    always_comb begin
        grant_o = valid_i & (~valid_i + NREQ'(1));
    end
`endif

    // Encode the one-hot grant into an index.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_o = idx_o | (grant_o[i] ? IDW'(i) : '0);
        end
        any_o = |valid_i;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port word RAM among NREQ requesters, one transaction per
// IDLE/DONE -> ISSUE -> DONE pass. Define RAM_ARB_RR_EN for round-robin arbitration.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int AW        = 25,
    parameter int MEM_WORDS = 33554432
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic [NREQ-1:0]   REQ_WE,
    input  logic [NREQ*AW-1:0] REQ_A,
    input  logic [NREQ*32-1:0] REQ_D,
    output logic [NREQ-1:0]   RSP_VALID,
    output logic              RSP_ERR,
    output logic [31:0]       RSP_Q,
    output logic [31:0]       RAM_A,
    output logic [31:0]       RAM_D,
    output logic              RAM_WE,
    input  logic [31:0]       RAM_Q
);

    localparam int IDW = id_width(NREQ);

    state_e            state_q;
    logic [IDW-1:0]    id_q;
    logic [AW-1:0]     a_q;
    logic [31:0]       d_q;
    logic              we_q;
    logic              err_q;
    logic              ram_we_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic              rsp_err_q;

    logic [IDW-1:0]    ptr_s;
    logic [NREQ-1:0]   grant_s;
    logic [IDW-1:0]    idx_s;
    logic              any_s;
    logic [AW-1:0]     sel_a_s;
    logic [31:0]       sel_d_s;
    logic              sel_we_s;
    logic              oor_s;
    logic [NREQ-1:0]   id_onehot_s;

    ram_arb_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid_i (REQ_VALID),
        .ptr_i   (ptr_s),
        .grant_o (grant_s),
        .idx_o   (idx_s),
        .any_o   (any_s)
    );

    // AND-OR mux of the winner's request fields and range check.
    always_comb begin
        sel_a_s = '0;
        sel_d_s = 32'h0;
        for (int i = 0; i < NREQ; i++) begin
            sel_a_s = sel_a_s | (REQ_A[i*AW +: AW] & {AW{grant_s[i]}});
            sel_d_s = sel_d_s | (REQ_D[i*32 +: 32] & {32{grant_s[i]}});
        end
        sel_we_s = |(REQ_WE & grant_s);
        oor_s    = (64'(sel_a_s) >= 64'(MEM_WORDS));
    end

    // Decode the owning requester for the response pulse.
    always_comb begin
        id_onehot_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            id_onehot_s[i] = (id_q == IDW'(i));
        end
    end

`ifdef RAM_ARB_RR_EN
    logic [IDW-1:0] ptr_q;

    // Remember the last accepted requester for the rotating search.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ptr_q <= IDW'(NREQ - 1);
        end else if (state_q != ISSUE && any_s) begin
            ptr_q <= idx_s;
        end else begin
            ptr_q <= ptr_q;
        end
    end
    assign ptr_s = ptr_q;
`else
    assign ptr_s = IDW'(NREQ - 1);
`endif

    // Transaction FSM; RAM_WE is only ever high during ISSUE.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            id_q        <= '0;
            a_q         <= '0;
            d_q         <= 32'h0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            ram_we_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ram_we_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (any_s) begin
                        state_q  <= ISSUE;
                        id_q     <= idx_s;
                        a_q      <= sel_a_s;
                        d_q      <= sel_d_s;
                        we_q     <= sel_we_s;
                        err_q    <= oor_s;
                        ram_we_q <= sel_we_s & ~oor_s;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                ISSUE: begin
                    state_q     <= DONE;
                    rsp_valid_q <= id_onehot_s;
                    rsp_err_q   <= err_q;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // READY is held low while reset is asserted even though arbitration is combinational.
    assign REQ_READY = (RSTN && state_q != ISSUE) ? grant_s : '0;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_ERR   = rsp_err_q;
    assign RSP_Q     = (state_q == DONE && !we_q && !err_q) ? RAM_Q : 32'h0;
    assign RAM_A     = 32'(a_q);
    assign RAM_D     = d_q;
    assign RAM_WE    = ram_we_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural single-port RAM.
module tb_ram_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 8;
    localparam int MEMW = 200;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*AW-1:0] req_a;
    logic [NREQ*32-1:0] req_d;
    logic [NREQ-1:0]   rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_q;
    logic [31:0]       ram_a;
    logic [31:0]       ram_d;
    logic              ram_we;
    logic [31:0]       ram_q;
    logic [31:0]       mem [0:255];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.NREQ(NREQ), .AW(AW), .MEM_WORDS(MEMW)) dut (
        .CLK(clk), .RSTN(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
        .REQ_A(req_a), .REQ_D(req_d),
        .RSP_VALID(rsp_valid), .RSP_ERR(rsp_err), .RSP_Q(rsp_q),
        .RAM_A(ram_a), .RAM_D(ram_d), .RAM_WE(ram_we), .RAM_Q(ram_q)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_a[7:0]] <= ram_d;
        ram_q <= mem[ram_a[7:0]];
    end

    function automatic logic [1:0] oh(input int i);
        logic [1:0] one;
        one = 2'b01;
        return one << i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic we,
                           input logic [7:0] a, input logic [31:0] d);
        req_valid[r] = v;
        req_we[r]    = we;
        req_a[r*8 +: 8]   = a;
        req_d[r*32 +: 32] = d;
    endtask

    // Full transaction from IDLE back to IDLE, entered and left at edge+1.
    task automatic xact(input string tag, input int r, input logic we, input logic [7:0] a,
                        input logic [31:0] d, input logic exp_err, input logic [31:0] exp_q);
        set_req(r, 1'b1, we, a, d);
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(oh(r)));
        step();
        req_valid[r] = 1'b0;
        chk({tag, "_issue_we"}, 32'(ram_we), 32'(we & ~exp_err));
        chk({tag, "_issue_a"}, ram_a, {24'h0, a});
        if (we && !exp_err) chk({tag, "_issue_d"}, ram_d, d);
        chk({tag, "_issue_rdy"}, 32'(req_ready), 32'h0);
        chk({tag, "_issue_rsp"}, 32'(rsp_valid), 32'h0);
        step();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh(r)));
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, "_rsp_q"}, rsp_q, exp_q);
        chk({tag, "_done_we"}, 32'(ram_we), 32'h0);
        step();
        chk({tag, "_idle_rsp"}, 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_id;
        logic [1:0] nxt_id;
        req_valid = '0; req_we = '0; req_a = '0; req_d = '0;

        // Reset state, with requests pending to show READY is held off.
        req_valid = 2'b11;
        #2;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_rsp_q", rsp_q, 32'h0);
        chk("rst_ram_a", ram_a, 32'h0);
        chk("rst_ram_d", ram_d, 32'h0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        req_valid = 2'b00;
        step(); step();
        rst_n = 1'b1;
        step();

        // 1: write then read back on requester 0.
        xact("t1_wr", 0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        xact("t1_rd", 0, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // 3: range boundary.
        xact("t3_oor_rd", 0, 1'b0, 8'd200, 32'h0, 1'b1, 32'h0);
        xact("t3_oor_wr", 0, 1'b1, 8'd250, 32'h00000BAD, 1'b1, 32'h0);
        xact("t3_top_wr", 0, 1'b1, 8'd199, 32'h12345678, 1'b0, 32'h0);
        xact("t3_top_rd", 0, 1'b0, 8'd199, 32'h0, 1'b0, 32'h12345678);

        // 4: back-to-back on requester 1, re-request in its own DONE cycle.
        set_req(1, 1'b1, 1'b1, 8'd5, 32'h1);
        #1;
        chk("t4_ready_w", 32'(req_ready), 32'(2'b10));
        step();
        req_valid[1] = 1'b0;
        chk("t4_we_w", 32'(ram_we), 32'h1);
        step();
        chk("t4_rsp_w", 32'(rsp_valid), 32'(2'b10));
        set_req(1, 1'b1, 1'b0, 8'd5, 32'h0);
        #1;
        chk("t4_ready_r", 32'(req_ready), 32'(2'b10));
        step();
        req_valid[1] = 1'b0;
        chk("t4_issue_a", ram_a, 32'h5);
        chk("t4_issue_we", 32'(ram_we), 32'h0);
        step();
        chk("t4_rsp_r", 32'(rsp_valid), 32'(2'b10));
        chk("t4_rsp_q", rsp_q, 32'h1);
        step();

        // 2: contention, both requesters reading continuously.
        set_req(0, 1'b1, 1'b0, 8'h10, 32'h0);
        set_req(1, 1'b1, 1'b0, 8'd5, 32'h0);
        #1;
        chk("t2_ready0", 32'(req_ready), 32'(2'b01));
        for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_RR_EN
            exp_id = oh(k % 2);
            nxt_id = oh((k + 1) % 2);
`else
            exp_id = 2'b01;
            nxt_id = 2'b01;
`endif
            step();
            chk("t2_issue_rdy", 32'(req_ready), 32'h0);
            step();
            chk("t2_rsp_valid", 32'(rsp_valid), 32'(exp_id));
            chk("t2_rsp_q", rsp_q, (exp_id == 2'b10) ? 32'h1 : 32'hDEADBEEF);
            if (k < 3) chk("t2_done_rdy", 32'(req_ready), 32'(nxt_id));
        end
        req_valid = 2'b00;
        step();

        // 6: requester 0 waits while requester 1 owns the bus.
        set_req(1, 1'b1, 1'b1, 8'd7, 32'hA5A5A5A5);
        #1;
        chk("t6_ready1", 32'(req_ready), 32'(2'b10));
        step();
        req_valid[1] = 1'b0;
        set_req(0, 1'b1, 1'b0, 8'h10, 32'h0);
        #1;
        chk("t6_hold_rdy", 32'(req_ready), 32'h0);
        chk("t6_hold_a", ram_a, 32'h7);
        chk("t6_hold_d", ram_d, 32'hA5A5A5A5);
        step();
        chk("t6_rsp1", 32'(rsp_valid), 32'(2'b10));
        chk("t6_ready0", 32'(req_ready), 32'(2'b01));
        step();
        req_valid[0] = 1'b0;
        chk("t6_issue_a", ram_a, 32'h10);
        step();
        chk("t6_rsp0", 32'(rsp_valid), 32'(2'b01));
        chk("t6_rsp_q", rsp_q, 32'hDEADBEEF);
        step();

        // 5: reset during the ISSUE cycle of a write drops it.
        xact("t5_pre", 0, 1'b1, 8'h20, 32'h11111111, 1'b0, 32'h0);
        set_req(0, 1'b1, 1'b1, 8'h20, 32'h00000055);
        #1;
        chk("t5_ready", 32'(req_ready), 32'(2'b01));
        step();
        chk("t5_issue_we", 32'(ram_we), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_we", 32'(ram_we), 32'h0);
        chk("t5_rst_a", ram_a, 32'h0);
        chk("t5_rst_d", ram_d, 32'h0);
        chk("t5_rst_rdy", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        step();
        chk("t5_rst_rsp", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
        step();
        chk("t5_post_rsp1", 32'(rsp_valid), 32'h0);
        step();
        chk("t5_post_rsp2", 32'(rsp_valid), 32'h0);
        xact("t5_rd", 0, 1'b0, 8'h20, 32'h0, 1'b0, 32'h11111111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
